spi_top: RTL and testbench
==========================

Name: spi_top

Overview:
SPI-slave LED controller for the Zybo Z7-20 board.
- Receives 24-bit command frames (cmd, addr, payload) from an SPI master.
- Stores a 7-bit brightness per LED for 8 LEDs and drives each LED pin with a PWM output.
- Returns a stored brightness on MISO within the same frame when a read command is issued.
- Sits between the board SPI pins and the LED pins, all in the sysclk (125 MHz) domain.

Parameters:
NUM_LEDS, 8, number of LED channels (addresses 0..NUM_LEDS-1).
CMD_BITS, 8, command field width.
ADDR_BITS, 8, address field width.
PAYLOAD_BITS, 8, payload field width; brightness = payload[7:1] (7 bits).
FRAME_BITS, CMD_BITS+ADDR_BITS+PAYLOAD_BITS (24), frame length.
CMD_NOP / CMD_LED_SET / CMD_LED_READ, 8'h00 / 8'h01 / 8'h02, command codes.

Ports:
sysclk  in  1  system clock, 125 MHz; the single clock of the block.
rst_n  in  1  asynchronous active-low reset.
sclk  in  1  SPI clock from master, asynchronous to sysclk, max 26 MHz.
cs  in  1  SPI chip select, active low.
mosi  in  1  master-out data.
miso  out  1  slave-out data.
led1..led8  out  1 each  PWM outputs for LED addresses 0..7.

Behaviour:
- Reset: clear all brightness registers, PWM counter, shift register and bit counter; miso=0; led1..8=0.
- Inputs sclk, cs, mosi: each passes through a 2-FF synchronizer to sysclk.
- Edge detection is on the synchronized sclk; sysclk must be >=4x sclk.
- SPI mode 0: CPOL=0, CPHA=0, MSB first.
  - Slave samples mosi on sclk rising edges.
  - Slave updates miso on sclk falling edges.
- Frame start: cs falling edge clears the bit counter and shift register.
- sclk edges are ignored while cs is high.
- Frame layout, first bit first: cmd[7:0], addr[7:0], payload[7:0].
- Frame completion: on the 24th sampled bit, latch cmd/addr/payload.
- Commands execute one sysclk after latching, so new brightness is visible on PWM within 4 sysclk of the 24th sclk rising edge (synchronizer included).
- Bits beyond 24 in the same cs-low window are ignored.
- Abort: if cs rises before 24 bits, the frame is discarded with no state change.
- CMD_NOP: no effect.
- CMD_LED_SET: if addr < NUM_LEDS, brightness[addr] <= payload[7:1] (payload[0] ignored); otherwise ignored.
- CMD_LED_READ: no state change. Response is driven in the same frame:
  - After the 16th sampled bit, if addr < NUM_LEDS, load tx register with {brightness[addr], 1'b0}; otherwise load 8'h00.
  - On the 16th falling edge, drive tx MSB; shift out one bit per subsequent falling edge.
- Any other cmd value: treated as NOP.
- miso is 0 while cs is high, during bits 1..16, and for all non-READ frames.
- PWM:
  - 7-bit free-running counter, increments every sysclk, wraps 127->0 (period 128 cycles).
  - led(i+1) = (counter < brightness[i]).
  - Brightness 0 gives constant 0; brightness 127 gives high 127/128.
- Brightness registers hold their value until reset or a valid SET to that address.
- Reset asserted mid-frame: all state clears immediately.
  - After reset release, a frame already in progress (cs low) is discarded; the next cs falling edge starts a new frame.

Test Plan:
- Reset, then NOP frame {00,00,00} -> all brightness 0; led1..8 stay 0 over 256 sysclk; miso stays 0.
- SET {01,00,14} (brightness 0x0A) -> led1 high for exactly 10 of every 128 sysclk; other LEDs 0.
- SET {01,07,14} then SET {01,10,FE} (invalid addr 0x10) -> led8 duty 10/128, led1 duty unchanged at 10/128, no other LED changes.
- SET {01,03,00} after SET {01,03,FE} -> led4 first high 127/128, then constant 0.
- READ {02,07,xx} after LED7 set to 0x0A -> master captures 8'h14 on miso in payload phase; no brightness change.
- Abort: cs raised after 12 bits of SET {01,02,FE} -> led3 stays 0; next full frame decodes correctly. Also: rst_n pulse mid-frame -> all LEDs 0, miso 0.

Source files
------------

// File: rtl/spi_top.sv
`timescale 1ns/1ps
// SPI-slave LED controller. A mode-0 SPI master writes 24-bit frames
// {cmd, addr, payload} to set a 7-bit brightness per LED, or reads one back
// on miso during the payload phase of the same frame. Each LED is driven by
// a 128-cycle PWM. Everything runs on sysclk; the SPI pins are oversampled.
module spi_top #(
  parameter int unsigned NUM_LEDS     = 8,
  parameter int unsigned CMD_BITS     = 8,
  parameter int unsigned ADDR_BITS    = 8,
  parameter int unsigned PAYLOAD_BITS = 8,
  parameter int unsigned FRAME_BITS   = CMD_BITS + ADDR_BITS + PAYLOAD_BITS,
  parameter logic [CMD_BITS-1:0] CMD_NOP      = 8'h00,
  parameter logic [CMD_BITS-1:0] CMD_LED_SET  = 8'h01,
  parameter logic [CMD_BITS-1:0] CMD_LED_READ = 8'h02
) (
  input  logic sysclk,
  input  logic rst_n,
  input  logic sclk,
  input  logic cs,
  input  logic mosi,
  output logic miso,
  output logic led1,
  output logic led2,
  output logic led3,
  output logic led4,
  output logic led5,
  output logic led6,
  output logic led7,
  output logic led8
);

  localparam int unsigned BRIGHT_BITS = PAYLOAD_BITS - 1;
  localparam int unsigned HDR_BITS    = CMD_BITS + ADDR_BITS;
  localparam int unsigned CNT_W       = $clog2(FRAME_BITS + 1);

  // Synchronizer chains: [0] metastable stage, [1] synchronized, [2] previous
  // synchronized value used for edge detection.
  logic [2:0] sclk_sync_q;
  logic [2:0] cs_sync_q;
  logic [1:0] mosi_sync_q;

  logic sclk_rise;
  logic sclk_fall;
  logic cs_low;
  logic cs_fall;
  logic mosi_bit;

  // Frame reception state
  logic                    active_q;
  logic [CNT_W-1:0]        bit_cnt_q;
  logic [FRAME_BITS-2:0]   shift_q;
  logic [FRAME_BITS-1:0]   shift_next;
  logic                    sample;

  // Latched command, executed one sysclk after the last bit
  logic                    exec_q;
  logic [CMD_BITS-1:0]     cmd_q;
  logic [ADDR_BITS-1:0]    addr_q;
  logic [BRIGHT_BITS-1:0]  bright_new_q;

  // Read response
  logic                    is_read_q;
  logic [PAYLOAD_BITS-1:0] tx_q;
  logic                    miso_q;
  logic                    hdr_is_read;
  logic [ADDR_BITS-1:0]    hdr_addr;
  logic                    rd_hit;
  logic [BRIGHT_BITS-1:0]  rd_bright;
  logic [PAYLOAD_BITS-1:0] rd_word;

  // Brightness store and PWM
  logic [BRIGHT_BITS-1:0]  bright_q [NUM_LEDS];
  logic [BRIGHT_BITS-1:0]  pwm_q;
  logic [7:0]              led_vec;

  // Bring the asynchronous SPI pins into the sysclk domain. cs resets to the
  // "low" value so a frame already running at reset release shows no falling
  // edge and is therefore ignored until cs goes high and low again.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '0;
      mosi_sync_q <= '0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[1:0], sclk};
      cs_sync_q   <= {cs_sync_q[1:0], cs};
      mosi_sync_q <= {mosi_sync_q[0], mosi};
    end
  end

  assign sclk_rise  = sclk_sync_q[1] & ~sclk_sync_q[2];
  assign sclk_fall  = ~sclk_sync_q[1] & sclk_sync_q[2];
  assign cs_low     = ~cs_sync_q[1];
  assign cs_fall    = ~cs_sync_q[1] & cs_sync_q[2];
  assign mosi_bit   = mosi_sync_q[1];

  assign shift_next = {shift_q, mosi_bit};
  assign sample     = active_q && sclk_rise && (bit_cnt_q < CNT_W'(FRAME_BITS));

  // After 16 bits the shifter holds {cmd, addr}; decode it for a read.
  assign hdr_is_read = (shift_next[HDR_BITS-1:ADDR_BITS] == CMD_LED_READ);
  assign hdr_addr    = shift_next[ADDR_BITS-1:0];

  // Look up the brightness addressed by the frame header (0 when out of range).
  always_comb begin
    rd_hit    = 1'b0;
    rd_bright = '0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      if (hdr_addr == ADDR_BITS'(i)) begin
        rd_hit    = 1'b1;
        rd_bright = bright_q[i];
      end
    end
    rd_word = rd_hit ? {rd_bright, 1'b0} : '0;
  end

  // Shift in frame bits, latch the completed frame, and shift out read data.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      active_q     <= 1'b0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      exec_q       <= 1'b0;
      cmd_q        <= '0;
      addr_q       <= '0;
      bright_new_q <= '0;
      is_read_q    <= 1'b0;
      tx_q         <= '0;
      miso_q       <= 1'b0;
    end else begin
      exec_q <= 1'b0;
      if (cs_fall) begin
        active_q  <= 1'b1;
        bit_cnt_q <= '0;
        shift_q   <= '0;
        is_read_q <= 1'b0;
        tx_q      <= '0;
        miso_q    <= 1'b0;
      end else if (!cs_low) begin
        // cs high: any partial frame is dropped without side effects
        active_q  <= 1'b0;
        is_read_q <= 1'b0;
        tx_q      <= '0;
        miso_q    <= 1'b0;
      end else if (active_q) begin
        if (sample) begin
          shift_q   <= shift_next[FRAME_BITS-2:0];
          bit_cnt_q <= bit_cnt_q + 1'b1;
          if (bit_cnt_q == CNT_W'(HDR_BITS - 1)) begin
            is_read_q <= hdr_is_read;
            tx_q      <= hdr_is_read ? rd_word : '0;
          end
          if (bit_cnt_q == CNT_W'(FRAME_BITS - 1)) begin
            cmd_q        <= shift_next[FRAME_BITS-1:HDR_BITS];
            addr_q       <= shift_next[HDR_BITS-1:PAYLOAD_BITS];
            bright_new_q <= shift_next[PAYLOAD_BITS-1:1];
            exec_q       <= 1'b1;
          end
        end
        // First falling edge after the header drives the response MSB
        if (sclk_fall && is_read_q && (bit_cnt_q >= CNT_W'(HDR_BITS))) begin
          miso_q <= tx_q[PAYLOAD_BITS-1];
          tx_q   <= {tx_q[PAYLOAD_BITS-2:0], 1'b0};
        end
      end
    end
  end

  assign miso = miso_q;

  // Execute the latched command; only a SET to a valid address changes state.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_LEDS; i++) begin
        bright_q[i] <= '0;
      end
    end else if (exec_q) begin
      case (cmd_q)
        CMD_LED_SET: begin
          for (int i = 0; i < NUM_LEDS; i++) begin
            if (addr_q == ADDR_BITS'(i)) begin
              bright_q[i] <= bright_new_q;
            end
          end
        end
        CMD_NOP, CMD_LED_READ: ;
        default: ;
      endcase
    end
  end

  // Free-running PWM phase counter, wraps naturally at 2^BRIGHT_BITS.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_q <= '0;
    end else begin
      pwm_q <= pwm_q + 1'b1;
    end
  end

  for (genvar i = 0; i < 8; i++) begin : g_led
    if (i < NUM_LEDS) begin : g_used
      assign led_vec[i] = (pwm_q < bright_q[i]);
    end else begin : g_unused
      assign led_vec[i] = 1'b0;
    end
  end

  assign led1 = led_vec[0];
  assign led2 = led_vec[1];
  assign led3 = led_vec[2];
  assign led4 = led_vec[3];
  assign led5 = led_vec[4];
  assign led6 = led_vec[5];
  assign led7 = led_vec[6];
  assign led8 = led_vec[7];

endmodule

// File: tb/tb_spi_top.sv
`timescale 1ns/1ps
// Bench for spi_top: a bit-banged mode-0 SPI master, a brightness/PWM-phase
// model, a per-cycle LED/miso comparator, and directed plus random frames.
module tb_spi_top;

  logic sysclk = 1'b0;
  logic rst_n  = 1'b0;
  logic sclk   = 1'b0;
  logic cs     = 1'b1;
  logic mosi   = 1'b0;
  logic miso;
  logic led1, led2, led3, led4, led5, led6, led7, led8;
  logic [7:0] leds;

  spi_top dut (
    .sysclk (sysclk),
    .rst_n  (rst_n),
    .sclk   (sclk),
    .cs     (cs),
    .mosi   (mosi),
    .miso   (miso),
    .led1   (led1),
    .led2   (led2),
    .led3   (led3),
    .led4   (led4),
    .led5   (led5),
    .led6   (led6),
    .led7   (led7),
    .led8   (led8)
  );

  always #4 sysclk = ~sysclk;

  assign leds = {led8, led7, led6, led5, led4, led3, led2, led1};

  int tests = 0;
  int fails = 0;
  int bright_m [8];
  int unsigned phase;  // sysclk cycles since reset release, modulo the PWM period
  bit check_en = 1'b0;

  always @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) phase <= 0;
    else        phase <= (phase + 1) % 128;
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Between frames every LED must follow phase < brightness and miso is idle.
  always @(negedge sysclk) begin
    if (check_en) begin
      for (int i = 0; i < 8; i++) begin
        check($sformatf("led%0d", i + 1), int'(leds[i]),
              (int'(phase) < bright_m[i]) ? 1 : 0);
      end
      check("miso_idle", int'(miso), 0);
    end
  end

  task automatic settle();
    repeat (8) @(posedge sysclk);
    @(negedge sysclk);
    check_en = 1'b1;
  endtask

  // Clock out frame bits first..last-1; check miso at each rising edge.
  task automatic clock_bits(input logic [23:0] f, input int first, input int last,
                            input int hp, input bit is_rd, input logic [7:0] exp_rd,
                            inout logic [7:0] rx);
    for (int k = first; k < last; k++) begin
      int r;
      int e;
      r = k + 1;
      mosi = (k < 24) ? f[23-k] : 1'($urandom);
      #(hp);
      sclk = 1'b1;
      e = (is_rd && r >= 17 && r <= 24) ? int'(exp_rd[24-r]) : 0;
      check($sformatf("miso_bit%0d", r), int'(miso), e);
      if (r >= 17 && r <= 24) rx[24-r] = miso;
      #(hp);
      sclk = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [7:0] a, input logic [7:0] p,
                            input int nbits, output logic [7:0] rx);
    int hp;
    int b;
    bit is_rd;
    logic [7:0] exp_rd;
    check_en = 1'b0;
    hp = $urandom_range(48, 80);
    is_rd = (c == 8'h02);
    exp_rd = 8'h00;
    if (is_rd && a < 8) begin
      b = bright_m[a[2:0]];
      exp_rd = {b[6:0], 1'b0};
    end
    rx = 8'h00;
    #(hp);
    cs = 1'b0;
    clock_bits({c, a, p}, 0, nbits, hp, is_rd, exp_rd, rx);
    #(hp);
    cs = 1'b1;
    if (nbits >= 24 && c == 8'h01 && a < 8) bright_m[a[2:0]] = int'(p[7:1]);
    settle();
  endtask

  task automatic duty(input int idx, output int n);
    n = 0;
    repeat (128) begin
      @(negedge sysclk);
      n += int'(leds[idx]);
    end
  endtask

  task automatic do_reset(input int cycles);
    check_en = 1'b0;
    rst_n = 1'b0;
    for (int i = 0; i < 8; i++) bright_m[i] = 0;
    repeat (cycles) @(posedge sysclk);
    #1;
    check("rst_leds", int'(leds), 0);
    check("rst_miso", int'(miso), 0);
    @(negedge sysclk);
    rst_n = 1'b1;
    check_en = 1'b1;
  endtask

  initial begin
    logic [7:0] rx, c, a, p;
    int n, nb, sel, hp;

    do_reset(5);

    // NOP: nothing lights, nothing returned
    send_frame(8'h00, 8'h00, 8'h00, 24, rx);
    n = 0;
    repeat (256) begin
      @(negedge sysclk);
      if (leds != 8'h00) n++;
    end
    check("nop_led_cycles", n, 0);
    check("nop_rx", int'(rx), 0);

    // SET led1 to 0x0A
    send_frame(8'h01, 8'h00, 8'h14, 24, rx);
    duty(0, n); check("set0_duty_led1", n, 10);
    duty(1, n); check("set0_duty_led2", n, 0);

    // SET led8, then an out-of-range address
    send_frame(8'h01, 8'h07, 8'h14, 24, rx);
    send_frame(8'h01, 8'h10, 8'hFE, 24, rx);
    duty(7, n); check("set7_duty_led8", n, 10);
    duty(0, n); check("keep_duty_led1", n, 10);

    // Full scale then off
    send_frame(8'h01, 8'h03, 8'hFE, 24, rx);
    duty(3, n); check("max_duty_led4", n, 127);
    send_frame(8'h01, 8'h03, 8'h00, 24, rx);
    duty(3, n); check("zero_duty_led4", n, 0);

    // Reads: valid, another valid, out of range
    send_frame(8'h02, 8'h07, 8'h55, 24, rx);
    check("read_led8", int'(rx), 8'h14);
    duty(7, n); check("read_keeps_led8", n, 10);
    send_frame(8'h02, 8'h00, 8'h00, 24, rx);
    check("read_led1", int'(rx), 8'h14);
    send_frame(8'h02, 8'h20, 8'h00, 24, rx);
    check("read_bad_addr", int'(rx), 0);

    // Abort after 12 bits, then a good frame
    send_frame(8'h01, 8'h02, 8'hFE, 12, rx);
    duty(2, n); check("abort_led3", n, 0);
    send_frame(8'h01, 8'h02, 8'h40, 24, rx);
    duty(2, n); check("after_abort_led3", n, 32);

    // Extra bits past 24 are ignored
    send_frame(8'h01, 8'h05, 8'h20, 30, rx);
    duty(5, n); check("extra_bits_led6", n, 16);

    // Reset in the middle of a frame; the rest of that frame is discarded
    send_frame(8'h01, 8'h00, 8'hFE, 24, rx);
    check_en = 1'b0;
    hp = 60;
    rx = 8'h00;
    #(hp);
    cs = 1'b0;
    clock_bits(24'h0102FE, 0, 10, hp, 1'b0, 8'h00, rx);
    rst_n = 1'b0;
    for (int i = 0; i < 8; i++) bright_m[i] = 0;
    repeat (3) @(posedge sysclk);
    #1;
    check("midrst_leds", int'(leds), 0);
    check("midrst_miso", int'(miso), 0);
    @(negedge sysclk);
    rst_n = 1'b1;
    clock_bits(24'h0102FE, 10, 24, hp, 1'b0, 8'h00, rx);
    #(hp);
    cs = 1'b1;
    settle();
    duty(2, n); check("midrst_led3", n, 0);
    duty(0, n); check("midrst_led1", n, 0);
    send_frame(8'h01, 8'h04, 8'h0C, 24, rx);
    duty(4, n); check("post_rst_led5", n, 6);

    // Random frames against the model
    for (int t = 0; t < 40; t++) begin
      sel = $urandom_range(0, 3);
      c = (sel == 3) ? 8'($urandom) : 8'(sel);
      a = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 9));
      p = 8'($urandom);
      sel = $urandom_range(0, 9);
      nb = (sel == 0) ? $urandom_range(1, 23) : (sel == 1) ? $urandom_range(25, 30) : 24;
      send_frame(c, a, p, nb, rx);
      repeat ($urandom_range(0, 100)) @(negedge sysclk);
    end

    check_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
